fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the main/ALU decoder controller.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents opcode/funct to the controller with a valid/ready handshake.
- Computes the next PC from the controller's pcsrc and jump outputs, plus the sign-extended immediate.

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, reads words over imem req/ack, and issues them to the controller.
// Optional macro FETCH_TIMEOUT_EN adds an ack wait limit with a sticky fetch_err and a HALT state.
module fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        pcsrc,
   input  logic        jump,
   input  logic [31:0] signimm,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err
);

   if (RESET_PC[1:0] != 2'b00 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("fetch_unit: RESET_PC must be word aligned and TIMEOUT_CYCLES >= 1");
   end

`ifdef FETCH_TIMEOUT_EN
   typedef enum logic [1:0] {FETCH = 2'd0, ISSUE = 2'd1, HALT = 2'd2} state_t;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;
`else
   typedef enum logic [1:0] {FETCH = 2'd0, ISSUE = 2'd1} state_t;
`endif

   state_t      state;
   logic [31:0] next_pc;

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   assign opcode    = instr[31:26];
   assign funct     = instr[5:0];

   // Handshake outputs come straight from the state register, forced low while reset is held.
   assign imem_req    = (state == FETCH) && !reset;
   assign instr_valid = (state == ISSUE) && !reset;

   // Jump wins over a taken branch; both targets wrap modulo 2^32.
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (pcsrc) begin
         next_pc = pc_plus4 + (signimm << 2);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         pc    <= RESET_PC;
         instr <= '0;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt  <= '0;
         fetch_err <= 1'b0;
`endif
      end else begin
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  instr <= imem_rdata;
                  state <= ISSUE;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  state     <= HALT;
                  fetch_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
`endif
            end
            ISSUE: begin
               if (instr_ready) begin
                  pc    <= next_pc;
                  state <= FETCH;
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
            end
`ifdef FETCH_TIMEOUT_EN
            HALT: begin
               state <= HALT;
            end
`endif
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

`ifndef FETCH_TIMEOUT_EN
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one table row per clock cycle, plus timeout/wait-forever sequences.
// Works in both builds; the FETCH_TIMEOUT_EN sequence assumes TIMEOUT_CYCLES=4.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        pcsrc = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] signimm = '0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_err;

   int n_checks = 0;
   int n_miss   = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .funct(funct),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pcsrc(pcsrc), .jump(jump), .signimm(signimm),
      .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
   );

   typedef struct {
      logic        rst, ack, rdy, br, jmp;
      logic [31:0] rdata, simm;
      logic        e_req, e_valid;
      logic [31:0] e_instr, e_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic ack, input logic [31:0] rdata,
                      input logic rdy, input logic br, input logic jmp, input logic [31:0] simm,
                      input logic e_req, input logic e_valid,
                      input logic [31:0] e_instr, input logic [31:0] e_pc);
      vec_t v;
      v.rst = rst; v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.br = br; v.jmp = jmp;
      v.simm = simm; v.e_req = e_req; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int row, input logic [31:0] got,
                        input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s row %0d: got %h want %h", name, row, got, want);
      end
   endtask

   localparam logic [31:0] I0  = 32'h2002_0005, I1  = 32'h0000_0020, I2  = 32'h8C43_0004;
   localparam logic [31:0] I3  = 32'hAC43_0008, I4  = 32'h1043_0002, I5  = 32'h0000_002A;
   localparam logic [31:0] I6  = 32'h2063_0001, I7  = 32'h0000_0022, I8  = 32'h0800_0010;
   localparam logic [31:0] I9  = 32'h3C01_1234, I10 = 32'h0000_0024, I11 = 32'h0000_0025;
   localparam logic [31:0] I12 = 32'h1000_FFFF;

   initial begin
      logic [31:0] ei;
      //   rst ack rdata          rdy br jmp simm            req val instr pc
      add(1, 0, 32'h0,          0, 0, 0, 32'h0,           0, 0, 32'h0, 32'h0);
      add(0, 1, I0,             0, 0, 0, 32'h0,           1, 0, 32'h0, 32'h0);
      add(0, 0, 32'h0,          1, 0, 0, 32'h0,           0, 1, I0,  32'h0);
      add(0, 1, I1,             0, 0, 0, 32'h0,           1, 0, I0,  32'h4);
      add(0, 0, 32'h0,          1, 0, 0, 32'h0,           0, 1, I1,  32'h4);
      add(0, 1, I2,             0, 0, 0, 32'h0,           1, 0, I1,  32'h8);
      add(0, 0, 32'h0,          1, 0, 0, 32'h0,           0, 1, I2,  32'h8);
      add(0, 1, I3,             0, 0, 0, 32'h0,           1, 0, I2,  32'hC);
      add(0, 0, 32'h0,          1, 0, 0, 32'h0,           0, 1, I3,  32'hC);
      add(0, 1, I4,             0, 0, 0, 32'h0,           1, 0, I3,  32'h10);
      add(0, 0, 32'h0,          1, 1, 0, 32'hFFFF_FFFE,   0, 1, I4,  32'h10);
      add(0, 1, I5,             0, 0, 0, 32'h0,           1, 0, I4,  32'hC);
      add(0, 0, 32'h0,          1, 0, 0, 32'h0,           0, 1, I5,  32'hC);
      add(0, 1, I6,             0, 0, 0, 32'h0,           1, 0, I5,  32'h10);
      add(0, 0, 32'h0,          1, 1, 0, 32'h3,           0, 1, I6,  32'h10);
      // ack withheld three cycles: request and address must hold
      add(0, 0, 32'h0,          0, 0, 0, 32'h0,           1, 0, I6,  32'h20);
      add(0, 0, 32'h0,          0, 0, 0, 32'h0,           1, 0, I6,  32'h20);
      add(0, 0, 32'h0,          0, 0, 0, 32'h0,           1, 0, I6,  32'h20);
      add(0, 1, I7,             0, 0, 0, 32'h0,           1, 0, I6,  32'h20);
      // ready withheld five cycles, with a stray ack and controller noise
      add(0, 0, 32'h0,          0, 0, 0, 32'h0,           0, 1, I7,  32'h20);
      add(0, 1, 32'hDEAD_BEEF,  0, 0, 0, 32'h0,           0, 1, I7,  32'h20);
      add(0, 0, 32'h0,          0, 0, 0, 32'h0,           0, 1, I7,  32'h20);
      add(0, 0, 32'h0,          0, 1, 1, 32'h1234,        0, 1, I7,  32'h20);
      add(0, 0, 32'h0,          0, 0, 0, 32'h0,           0, 1, I7,  32'h20);
      add(0, 0, 32'h0,          1, 1, 0, 32'h0FFF_FFF7,   0, 1, I7,  32'h20);
      add(0, 1, I8,             0, 0, 0, 32'h0,           1, 0, I7,  32'h4000_0000);
      add(0, 0, 32'h0,          1, 1, 1, 32'h5,           0, 1, I8,  32'h4000_0000);
      add(0, 1, I9,             0, 0, 0, 32'h0,           1, 0, I8,  32'h4000_0040);
      add(0, 0, 32'h0,          1, 1, 0, 32'h2FFF_FFEE,   0, 1, I9,  32'h4000_0040);
      add(0, 1, I10,            0, 0, 0, 32'h0,           1, 0, I9,  32'hFFFF_FFFC);
      add(0, 0, 32'h0,          1, 0, 0, 32'h0,           0, 1, I10, 32'hFFFF_FFFC);
      add(0, 1, I11,            0, 0, 0, 32'h0,           1, 0, I10, 32'h0);
      add(0, 0, 32'h0,          1, 0, 0, 32'h0,           0, 1, I11, 32'h0);
      // reset lands mid-fetch at pc=4 together with an ack
      add(0, 0, 32'h0,          0, 0, 0, 32'h0,           1, 0, I11, 32'h4);
      add(1, 1, 32'hCAFE_F00D,  0, 0, 0, 32'h0,           0, 0, I11, 32'h4);
      add(0, 0, 32'h0,          0, 0, 0, 32'h0,           1, 0, 32'h0, 32'h0);
      add(0, 1, I12,            0, 0, 0, 32'h0,           1, 0, 32'h0, 32'h0);
      add(0, 0, 32'h0,          0, 0, 0, 32'h0,           0, 1, I12, 32'h0);

      @(negedge clk);
      foreach (vecs[i]) begin
         reset = vecs[i].rst; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
         instr_ready = vecs[i].rdy; pcsrc = vecs[i].br; jump = vecs[i].jmp;
         signimm = vecs[i].simm;
         #1;
         ei = vecs[i].e_instr;
         check("imem_req",    i, {31'd0, imem_req},    {31'd0, vecs[i].e_req});
         check("instr_valid", i, {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
         check("instr",       i, instr,     ei);
         check("opcode",      i, {26'd0, opcode}, {26'd0, ei[31:26]});
         check("funct",       i, {26'd0, funct},  {26'd0, ei[5:0]});
         check("pc",          i, pc,        vecs[i].e_pc);
         check("imem_addr",   i, imem_addr, vecs[i].e_pc);
         check("pc_plus4",    i, pc_plus4,  vecs[i].e_pc + 32'd4);
         check("fetch_err",   i, {31'd0, fetch_err}, 32'd0);
         @(negedge clk);
      end

      // Hand sequence: ack never arrives after a fresh reset
      reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; pcsrc = 1'b0; jump = 1'b0;
      @(negedge clk);
      reset = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      for (int k = 1; k <= 4; k++) begin
         #1;
         check("to_wait_req", 100 + k, {31'd0, imem_req},  32'd1);
         check("to_wait_err", 100 + k, {31'd0, fetch_err}, 32'd0);
         @(negedge clk);
      end
      imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("halt_err",   110 + k, {31'd0, fetch_err},   32'd1);
         check("halt_req",   110 + k, {31'd0, imem_req},    32'd0);
         check("halt_valid", 110 + k, {31'd0, instr_valid}, 32'd0);
         check("halt_pc",    110 + k, pc,    32'h0);
         check("halt_instr", 110 + k, instr, 32'h0);
         @(negedge clk);
      end
      imem_ack = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_reset_err", 120, {31'd0, fetch_err}, 32'd0);
      check("post_reset_req", 120, {31'd0, imem_req},  32'd1);
`else
      repeat (20) @(negedge clk);
      #1;
      check("wait_req",  200, {31'd0, imem_req},    32'd1);
      check("wait_addr", 200, imem_addr,            32'h0);
      check("wait_err",  200, {31'd0, fetch_err},   32'd0);
      check("wait_val",  200, {31'd0, instr_valid}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
      $finish;
   end

endmodule
